// File: rtl/csr_port_arbiter_if.sv
// csr_port_arbiter_if: requester-side bundle of the CSR port arbiter.
// master = application sub-blocks (issue requests, take responses),
// slave  = arbiter (grants requests, returns completions).
interface csr_port_arbiter_if #(
    parameter int NUM_REQUESTERS    = 4,
    parameter int CSR_DATA_WIDTH    = 32,
    parameter int CSR_ADDRESS_WIDTH = 16
);
    logic [NUM_REQUESTERS-1:0]                   req_valid;
    logic [NUM_REQUESTERS-1:0]                   req_ready;
    logic [NUM_REQUESTERS-1:0]                   req_write;
    logic [NUM_REQUESTERS*CSR_ADDRESS_WIDTH-1:0] req_address;
    logic [NUM_REQUESTERS*CSR_DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQUESTERS-1:0]                   rsp_valid;
    logic [CSR_DATA_WIDTH-1:0]                   rsp_data;

    modport master (
        output req_valid, req_write, req_address, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter: round-robin share of the DPRAM CSR port A.
// Ports: clock/reset_n; bus (slave) = per-requester valid/ready,
// write/address/data and one-hot rsp_valid + shared rsp_data;
// CSR_* = DPRAM write/read strobes, addresses, data, read data in.
module csr_port_arbiter #(
    parameter int NUM_REQUESTERS    = 4,
    parameter int CSR_DATA_WIDTH    = 32,
    parameter int CSR_ADDRESS_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    csr_port_arbiter_if.slave            bus,
    output logic                         CSR_write_enable,
    output logic [CSR_DATA_WIDTH-1:0]    CSR_write_data,
    output logic [CSR_ADDRESS_WIDTH-1:0] CSR_write_address,
    output logic                         CSR_read_enable,
    output logic [CSR_ADDRESS_WIDTH-1:0] CSR_read_address,
    input  logic [CSR_DATA_WIDTH-1:0]    CSR_read_data
);
    localparam int N  = NUM_REQUESTERS;
    localparam int DW = CSR_DATA_WIDTH;
    localparam int AW = CSR_ADDRESS_WIDTH;
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] scan_idx;
    logic          gnt_any;
    logic          accept;
    logic          gnt_write;
    logic [AW-1:0] gnt_address;
    logic [DW-1:0] gnt_data;

    logic          s1_valid;
    logic [IW-1:0] s1_index;
    logic          s2_valid;
    logic [IW-1:0] s2_index;

    // Scan from the farthest slot back toward ptr so the requester
    // closest to ptr (in wrap order) is the one left in gnt_idx.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = IW'((int'(ptr) + k) % N);
            if (bus.req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Grant is suppressed while reset is held.
    assign accept = reset_n && gnt_any;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_write   = bus.req_write[gnt_idx];
    assign gnt_address = bus.req_address[int'(gnt_idx)*AW +: AW];
    assign gnt_data    = bus.req_data[int'(gnt_idx)*DW +: DW];

    assign ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_next;
        end
    end

    // Issue stage: strobes are loaded every cycle, address/data only
    // on the matching kind of acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid          <= 1'b0;
            s1_index          <= '0;
            CSR_write_enable  <= 1'b0;
            CSR_read_enable   <= 1'b0;
            CSR_write_address <= '0;
            CSR_write_data    <= '0;
            CSR_read_address  <= '0;
        end else begin
            s1_valid         <= accept;
            s1_index         <= gnt_idx;
            CSR_write_enable <= accept && gnt_write;
            CSR_read_enable  <= accept && !gnt_write;
            if (accept && gnt_write) begin
                CSR_write_address <= gnt_address;
                CSR_write_data    <= gnt_data;
            end
            if (accept && !gnt_write) begin
                CSR_read_address <= gnt_address;
            end
        end
    end

    // Response stage lines up with the DPRAM's registered read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_index <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_index <= s1_index;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (s2_valid) begin
            bus.rsp_valid[s2_index] = 1'b1;
        end
    end

    assign bus.rsp_data = CSR_read_data;

endmodule
